// File: rtl/pe_pkg.sv
// pe_pkg -- shared definitions for the reversible-PE error logger.
//   state_t     : logger FSM encoding (also visible in the status register)
//   ADDR_*      : read-port register addresses
//   ID_CONST    : fixed identification word returned at ADDR_ID
package pe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b01,
        ST_ARMED = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic [1:0]  ADDR_CNT    = 2'd0;
    localparam logic [1:0]  ADDR_FIRST  = 2'd1;
    localparam logic [1:0]  ADDR_STATUS = 2'd2;
    localparam logic [1:0]  ADDR_ID     = 2'd3;

    localparam logic [15:0] ID_CONST    = 16'h5E01;

endpackage

// File: rtl/sat_counter.sv
// sat_counter -- up-counter that sticks at its all-ones value.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : add one this cycle (ignored once saturated)
//   clr        : synchronous zero, wins over inc
//   count      : current value
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pe_err_logger.sv
// pe_err_logger -- counts reverse-check mismatches of a reversible PE during
// one run (START .. end of busy) and records where the first one happened.
//   clk, rst_n       : clock, asynchronous active-low reset
//   start            : arm / restart a run (clears all run state)
//   busy             : PE is in WORK; advances the cycle index
//   err1, err2       : multiplier / adder reverse-check mismatch flags
//   clr              : synchronous clear to IDLE, wins over start
//   rd_en, rd_addr   : register read request and select
//   rd_data,rd_valid : read response
//   err_any          : sticky "an error was counted this run"
//   done             : run finished (busy fell while armed)
//
// Read handshake: rd_en is a request sampled on every clock edge with no
// backpressure; exactly one cycle later rd_valid is high and rd_data holds the
// selected register as it was before that edge. When rd_valid is low, rd_data
// is zero.
module pe_err_logger
    import pe_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int CYC_W = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        busy,
    input  logic        err1,
    input  logic        err2,
    input  logic        clr,
    input  logic        rd_en,
    input  logic [1:0]  rd_addr,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        err_any,
    output logic        done
);

    state_t             r_state;
    logic               r_busy_q;
    logic               r_done;
    logic               r_err_any;
    logic               r_first_vld;
    logic [1:0]         r_src;
    logic [CYC_W-1:0]   r_first_idx;
    logic [15:0]        r_rd_data;
    logic               r_rd_valid;

    logic               w_armed;
    logic               w_zero;
    logic               w_err;
    logic [CNT_W-1:0]   w_err1_cnt;
    logic [CNT_W-1:0]   w_err2_cnt;
    logic [CYC_W-1:0]   w_cyc;
    logic [15:0]        w_rd_mux;

    assign w_armed = (r_state == ST_ARMED);
    // Arm and clear both wipe the counters, so one zero strobe serves both.
    assign w_zero  = clr | start;
    assign w_err   = w_armed & (err1 | err2);

    sat_counter #(.WIDTH(CNT_W)) u_err1_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_armed & err1),
        .clr   (w_zero),
        .count (w_err1_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_err2_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_armed & err2),
        .clr   (w_zero),
        .count (w_err2_cnt)
    );

    sat_counter #(.WIDTH(CYC_W)) u_cyc_idx (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_armed & busy),
        .clr   (w_zero),
        .count (w_cyc)
    );

    // Run-control FSM with its registered flags and first-error record.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_busy_q    <= 1'b0;
            r_done      <= 1'b0;
            r_err_any   <= 1'b0;
            r_first_vld <= 1'b0;
            r_src       <= 2'b00;
            r_first_idx <= '0;
        end else begin
            r_busy_q <= busy;
            if (clr) begin
                r_state     <= ST_IDLE;
                r_done      <= 1'b0;
                r_err_any   <= 1'b0;
                r_first_vld <= 1'b0;
                r_src       <= 2'b00;
                r_first_idx <= '0;
            end else if (start) begin
                // Arming from any state, including a restart while armed.
                r_state     <= ST_ARMED;
                r_done      <= 1'b0;
                r_err_any   <= 1'b0;
                r_first_vld <= 1'b0;
                r_src       <= 2'b00;
                r_first_idx <= '0;
            end else if (w_armed) begin
                if (w_err) begin
                    r_err_any <= 1'b1;
                    if (!r_first_vld) begin
                        r_first_vld <= 1'b1;
                        r_src       <= {err2, err1};
                        r_first_idx <= w_cyc;
                    end
                end
                // Falling edge of busy ends the run.
                if (r_busy_q && !busy) begin
                    r_state <= ST_DONE;
                    r_done  <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_rd_mux = 16'h0000;
        case (rd_addr)
            ADDR_CNT:    w_rd_mux = {8'(w_err2_cnt), 8'(w_err1_cnt)};
            ADDR_FIRST:  w_rd_mux = {r_first_vld, r_src, 1'b0, 12'(r_first_idx)};
            ADDR_STATUS: w_rd_mux = {r_state, r_done, r_err_any, 12'(w_cyc)};
            ADDR_ID:     w_rd_mux = ID_CONST;
            default:     w_rd_mux = 16'h0000;
        endcase
    end

    // Registered read port: sampling pre-edge values gives the pre-update view.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data  <= 16'h0000;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            r_rd_data  <= rd_en ? w_rd_mux : 16'h0000;
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign err_any  = r_err_any;
    assign done     = r_done;

endmodule

// File: tb/tb_pe_err_logger.sv
module tb_pe_err_logger;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start = 1'b0;
    logic        busy = 1'b0;
    logic        err1 = 1'b0;
    logic        err2 = 1'b0;
    logic        clr = 1'b0;
    logic        rd_en = 1'b0;
    logic [1:0]  rd_addr = 2'd0;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        err_any;
    logic        done;

    always #5 clk = ~clk;

    pe_err_logger #(.CNT_W(8), .CYC_W(12)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .busy     (busy),
        .err1     (err1),
        .err2     (err2),
        .clr      (clr),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .err_any  (err_any),
        .done     (done)
    );

    // ---------------- scoreboard ----------------
    // Expected word: {done, err_any, rd_data} seen when rd_valid is high.
    logic [17:0] exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          errors = 0;
    logic        mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (rd_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rd_valid: got rd_data=%h with no read pending", rd_data);
                end else begin
                    logic [17:0] exp_w;
                    string       nm;
                    exp_w = exp_q.pop_front();
                    nm    = name_q.pop_front();
                    if ({done, err_any, rd_data} !== exp_w) begin
                        errors++;
                        $display("FAIL %s: got done=%b err_any=%b rd_data=%h, expected done=%b err_any=%b rd_data=%h",
                                 nm, done, err_any, rd_data, exp_w[17], exp_w[16], exp_w[15:0]);
                    end
                end
            end else begin
                checks++;
                if (rd_data !== 16'h0000) begin
                    errors++;
                    $display("FAIL idle_rd_data: got %h while rd_valid=0, expected 0000", rd_data);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cycn(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic rd(input logic [1:0] a, input logic [15:0] d,
                      input logic dn, input logic ea, input string nm);
        rd_en   = 1'b1;
        rd_addr = a;
        exp_q.push_back({dn, ea, d});
        name_q.push_back(nm);
        cyc();
        rd_en   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        mon_en = 1'b1;
        cycn(3);
        rst_n = 1'b1;
        cyc();

        // Reset state: IDLE=01 -> status 4000.
        rd(2'd0, 16'h0000, 1'b0, 1'b0, "rst_addr0");
        rd(2'd1, 16'h0000, 1'b0, 1'b0, "rst_addr1");
        rd(2'd2, 16'h4000, 1'b0, 1'b0, "rst_addr2");
        rd(2'd3, 16'h5E01, 1'b0, 1'b0, "rst_addr3");

        // Run 1: 16 busy cycles, single err1 at cycle index 5.
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            busy = 1'b1;
            err1 = (i == 5);
            cyc();
        end
        busy = 1'b0;
        err1 = 1'b0;
        cyc();                                   // busy fell -> DONE
        rd(2'd0, 16'h0001, 1'b1, 1'b1, "run1_addr0");
        // first_vld=1, src=2'b01, pad 0 -> top nibble A, index 005
        rd(2'd1, 16'hA005, 1'b1, 1'b1, "run1_addr1");
        // DONE=11, done=1, err_any=1, index 16
        rd(2'd2, 16'hF010, 1'b1, 1'b1, "run1_addr2");

        // Errors while DONE are ignored.
        err1 = 1'b1;
        err2 = 1'b1;
        cyc();
        err1 = 1'b0;
        err2 = 1'b0;
        rd(2'd0, 16'h0001, 1'b1, 1'b1, "done_ignore_addr0");
        rd(2'd1, 16'hA005, 1'b1, 1'b1, "done_ignore_addr1");
        rd(2'd3, 16'h5E01, 1'b1, 1'b1, "done_addr3");

        // Run 2: both errors at index 0; same-cycle read returns pre-update.
        pulse_start();
        busy = 1'b1;
        err1 = 1'b1;
        err2 = 1'b1;
        rd(2'd0, 16'h0000, 1'b0, 1'b1, "run2_pre_update");
        err1 = 1'b0;
        err2 = 1'b0;
        cycn(3);
        busy = 1'b0;
        cyc();
        rd(2'd0, 16'h0101, 1'b1, 1'b1, "run2_addr0");
        rd(2'd1, 16'hE000, 1'b1, 1'b1, "run2_addr1");
        rd(2'd2, 16'hF004, 1'b1, 1'b1, "run2_addr2");

        // Run 3: err1 held for 300 armed busy cycles -> saturates at 255.
        pulse_start();
        busy = 1'b1;
        err1 = 1'b1;
        cycn(300);
        busy = 1'b0;
        err1 = 1'b0;
        cyc();
        rd(2'd0, 16'h00FF, 1'b1, 1'b1, "sat_addr0");
        rd(2'd1, 16'hA000, 1'b1, 1'b1, "sat_addr1");
        rd(2'd2, 16'hF12C, 1'b1, 1'b1, "sat_addr2");

        // Restart while armed wipes the partial run.
        pulse_start();
        busy = 1'b1;
        err2 = 1'b1;
        cyc();
        err2 = 1'b0;
        cyc();
        busy = 1'b0;
        pulse_start();
        rd(2'd0, 16'h0000, 1'b0, 1'b0, "restart_addr0");
        rd(2'd1, 16'h0000, 1'b0, 1'b0, "restart_addr1");
        rd(2'd2, 16'h8000, 1'b0, 1'b0, "restart_addr2");

        // clr and start together: clr wins -> IDLE.
        busy = 1'b1;
        err1 = 1'b1;
        cycn(2);
        busy  = 1'b0;
        err1  = 1'b0;
        clr   = 1'b1;
        start = 1'b1;
        cyc();
        clr   = 1'b0;
        start = 1'b0;
        rd(2'd2, 16'h4000, 1'b0, 1'b0, "clr_start_addr2");
        rd(2'd0, 16'h0000, 1'b0, 1'b0, "clr_start_addr0");
        rd(2'd1, 16'h0000, 1'b0, 1'b0, "clr_start_addr1");

        // Reset mid-run after 3 errors discards everything.
        pulse_start();
        busy = 1'b1;
        err1 = 1'b1;
        cyc();
        err1 = 1'b0;
        err2 = 1'b1;
        cyc();
        err2 = 1'b0;
        err1 = 1'b1;
        cyc();
        err1 = 1'b0;
        rd(2'd0, 16'h0102, 1'b0, 1'b1, "prereset_addr0");
        cyc();
        rst_n = 1'b0;
        busy  = 1'b0;
        cycn(2);
        rst_n = 1'b1;
        cyc();
        rd(2'd0, 16'h0000, 1'b0, 1'b0, "midrst_addr0");
        rd(2'd1, 16'h0000, 1'b0, 1'b0, "midrst_addr1");
        rd(2'd2, 16'h4000, 1'b0, 1'b0, "midrst_addr2");
        rd(2'd3, 16'h5E01, 1'b0, 1'b0, "midrst_addr3");

        // Drain with a bounded wait.
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc();
        cycn(2);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d reads outstanding, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
